input_frame_assembler: RTL and testbench
========================================

INPUT_FRAME_ASSEMBLER -- requirements
Module: input_frame_assembler

Interface
REQ-001 SHALL have parameter N_BYTES, default 16, bytes per input frame (legal range 2..64).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 86800, idle cycles (10 byte times at 868 clk/bit) after which a partial frame is discarded.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8, byte from upstream UART receiver.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port frame_data, output, 8*N_BYTES, assembled frame; byte k at bits [8k+7:8k].
REQ-008 SHALL have port frame_valid, output, 1, frame_data complete and stable.
REQ-009 SHALL have port frame_ready, input, 1, downstream (network input layer) accepts frame.
REQ-010 SHALL have port byte_count, output, 7, bytes stored in current frame.
REQ-011 SHALL have port overrun, output, 1, sticky: byte dropped while frame held.
REQ-012 SHALL have port timeout_err, output, 1, one-cycle pulse on partial-frame discard.
REQ-013 SHALL have port led, output, 8, last byte accepted into the frame buffer.

Function
REQ-014 SHALL implement two states: COLLECT and HOLD.
REQ-015 In COLLECT, rx_valid=1 SHALL write rx_data to slot byte_count and increment byte_count the next cycle.
REQ-016 Writing slot N_BYTES-1 SHALL move to HOLD with frame_valid=1 and byte_count=N_BYTES on the following cycle (latency 1 clk from last rx_valid).
REQ-017 In HOLD, frame_data and frame_valid SHALL remain stable until frame_valid&frame_ready.
REQ-018 Handshake cycle (frame_valid&frame_ready) SHALL return to COLLECT, clear frame_valid, set byte_count=0 next cycle.
REQ-019 Bytes with rx_valid=1 in HOLD without handshake SHALL be dropped and set overrun=1 (sticky until reset); frame contents unchanged.
REQ-020 rx_valid coincident with handshake SHALL store the byte in slot 0 of the new frame (byte_count=1 next cycle); overrun not set.
REQ-021 frame_ready while frame_valid=0 SHALL be ignored.
REQ-022 An idle counter SHALL count cycles in COLLECT with byte_count>0 and rx_valid=0, clear on any rx_valid, and hold at 0 when byte_count=0 or in HOLD.
REQ-023 Idle counter reaching TIMEOUT_CYC-1 SHALL set byte_count=0, pulse timeout_err one cycle, and clear the counter; stored slot data need not be cleared.
REQ-024 rx_valid in the timeout cycle SHALL win: byte stored, no timeout.
REQ-025 led SHALL update to rx_data on every accepted byte (not on dropped bytes).
REQ-026 rx_data SHALL be sampled only when rx_valid=1; no other input sampling.

Reset
REQ-027 reset=1 SHALL force, next edge: state COLLECT, byte_count=0, frame_valid=0, overrun=0, timeout_err=0, led=0x00, idle counter=0, frame_data=0.
REQ-028 Reset mid-frame or in HOLD SHALL discard the frame; rx_valid during reset ignored.

Verification
REQ-029 N_BYTES=4: bytes 0x56,0x78,0x9A,0xBC with frame_ready=0 -> frame_valid=1 one clk after 4th, frame_data=0xBC9A7856, byte_count=4, led=0xBC.
REQ-030 Then frame_ready=1 one cycle -> frame_valid=0, byte_count=0 next cycle; overrun=0.
REQ-031 Full frame held, send 0x11 with frame_ready=0 -> overrun=1, frame_data unchanged, led unchanged; overrun stays 1 after handshake.
REQ-032 rx_valid with 0x22 in same cycle as handshake -> byte_count=1, frame_data[7:0]=0x22, overrun unchanged.
REQ-033 TIMEOUT_CYC=100: send 2 bytes, idle 100 cycles -> timeout_err single pulse, byte_count=0; next 4 bytes form clean frame.
REQ-034 Assert reset after 3 of 4 bytes -> byte_count=0, led=0x00; next 4 bytes produce a correct frame.

Source files
------------

// File: rtl/input_frame_assembler.sv
// Assembles N_BYTES UART bytes into one wide frame with a valid/ready handoff,
// an overrun flag for bytes dropped while a frame is held, and an idle timeout.
module input_frame_assembler #(
    parameter int unsigned N_BYTES     = 16,
    parameter int unsigned TIMEOUT_CYC = 86800
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [8*N_BYTES-1:0]   frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [6:0]             byte_count,
    output logic                   overrun,
    output logic                   timeout_err,
    output logic [7:0]             led
);

    localparam int unsigned FRAME_W = 8 * N_BYTES;
    localparam int unsigned IDLE_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned CNT_W   = 7;

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t               state, state_n;
    logic [FRAME_W-1:0]   frame_n;
    logic                 valid_n;
    logic [CNT_W-1:0]     cnt_n;
    logic                 ovr_n;
    logic                 to_n;
    logic [7:0]           led_n;
    logic [IDLE_W-1:0]    idle, idle_n;

    // State and all outputs registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            byte_count  <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            led         <= 8'h00;
            idle        <= '0;
        end else begin
            state       <= state_n;
            frame_data  <= frame_n;
            frame_valid <= valid_n;
            byte_count  <= cnt_n;
            overrun     <= ovr_n;
            timeout_err <= to_n;
            led         <= led_n;
            idle        <= idle_n;
        end
    end

    // Next-state: byte collection, hold/handshake, idle timeout
    always_comb begin
        state_n = state;
        frame_n = frame_data;
        valid_n = frame_valid;
        cnt_n   = byte_count;
        ovr_n   = overrun;
        to_n    = 1'b0;
        led_n   = led;
        idle_n  = idle;

        case (state)
            COLLECT: begin
                if (rx_valid) begin
                    for (int unsigned k = 0; k < N_BYTES; k++) begin
                        if (byte_count == CNT_W'(k)) begin
                            frame_n[8*k +: 8] = rx_data;
                        end
                    end
                    led_n  = rx_data;
                    idle_n = '0;
                    if (byte_count == CNT_W'(N_BYTES - 1)) begin
                        cnt_n   = CNT_W'(N_BYTES);
                        valid_n = 1'b1;
                        state_n = HOLD;
                    end else begin
                        cnt_n = CNT_W'(byte_count + CNT_W'(1));
                    end
                end else if (byte_count != '0) begin
                    if (idle == IDLE_W'(TIMEOUT_CYC - 1)) begin
                        cnt_n  = '0;
                        to_n   = 1'b1;
                        idle_n = '0;
                    end else begin
                        idle_n = IDLE_W'(idle + IDLE_W'(1));
                    end
                end else begin
                    idle_n = '0;
                end
            end
            HOLD: begin
                idle_n = '0;
                if (frame_ready) begin
                    valid_n = 1'b0;
                    state_n = COLLECT;
                    cnt_n   = '0;
                    // A byte arriving with the handshake opens the next frame
                    if (rx_valid) begin
                        frame_n[7:0] = rx_data;
                        led_n        = rx_data;
                        cnt_n        = CNT_W'(1);
                    end
                end else if (rx_valid) begin
                    ovr_n = 1'b1;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_input_frame_assembler.sv
// Directed bench for input_frame_assembler (N_BYTES=4, TIMEOUT_CYC=100) with a
// queue of expected frames popped whenever the DUT presents frame_valid.
module tb_input_frame_assembler;

    localparam int unsigned NB = 4;
    localparam int unsigned TO = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [8*NB-1:0]   frame_data;
    logic              frame_valid;
    logic              frame_ready;
    logic [6:0]        byte_count;
    logic              overrun;
    logic              timeout_err;
    logic [7:0]        led;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    input_frame_assembler #(.N_BYTES(NB), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .byte_count(byte_count), .overrun(overrun), .timeout_err(timeout_err), .led(led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        frame_ready = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        rx_valid = 1'b1;
        rx_data = b;
        frame_ready = rdy;
        tick();
    endtask

    task automatic send_frame(input logic [31:0] f);
        exp_q.push_back(f);
        for (int i = 0; i < 4; i++) begin
            send(f[8*i +: 8], 1'b0);
            if (i < 3) chk("partial_count", 32'(byte_count), 32'(i + 1));
        end
    endtask

    task automatic check_frame(input string tag);
        logic [31:0] e;
        chk({tag, "_valid"}, 32'(frame_valid), 32'd1);
        chk({tag, "_count"}, 32'(byte_count), 32'(NB));
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, frame_data, e);
            chk({tag, "_led"}, 32'(led), 32'(e[31:24]));
        end
    endtask

    task automatic handshake(input string tag);
        frame_ready = 1'b1;
        tick();
        chk({tag, "_valid_clr"}, 32'(frame_valid), 32'd0);
        chk({tag, "_count_clr"}, 32'(byte_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_ready = 1'b0;
        tick(); reset = 1'b1; tick();
        reset = 1'b0;
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_count", 32'(byte_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_data", frame_data, 32'd0);

        // Basic frame, latency 1 clk after 4th byte
        send_frame(32'hBC9A7856);
        check_frame("f1");
        tick();
        chk("f1_stable", frame_data, 32'hBC9A7856);
        handshake("f1");
        chk("f1_overrun", 32'(overrun), 32'd0);

        // Overrun while held
        send_frame(32'h04030201);
        check_frame("f2");
        send(8'h11, 1'b0);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_data", frame_data, 32'h04030201);
        chk("ovr_led", 32'(led), 32'h04);
        chk("ovr_valid", 32'(frame_valid), 32'd1);

        // Byte coincident with handshake
        send(8'h22, 1'b1);
        chk("hs_count", 32'(byte_count), 32'd1);
        chk("hs_byte0", 32'(frame_data[7:0]), 32'h22);
        chk("hs_valid", 32'(frame_valid), 32'd0);
        chk("hs_overrun", 32'(overrun), 32'd1);
        chk("hs_led", 32'(led), 32'h22);
        exp_q.push_back(32'h55443322);
        send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h55, 1'b0);
        check_frame("f3");
        handshake("f3");
        chk("f3_overrun_sticky", 32'(overrun), 32'd1);

        // frame_ready without frame_valid is ignored
        send(8'h66, 1'b0);
        frame_ready = 1'b1;
        tick();
        chk("rdy_ign_count", 32'(byte_count), 32'd1);
        chk("rdy_ign_valid", 32'(frame_valid), 32'd0);

        // Idle timeout on partial frame (idle counted from the 2nd byte here)
        send(8'h77, 1'b0);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_before", 32'(timeout_err), 32'd0);
        chk("to_before_count", 32'(byte_count), 32'd2);
        tick();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_count", 32'(byte_count), 32'd0);
        tick();
        chk("to_single", 32'(timeout_err), 32'd0);
        send_frame(32'hA4A3A2A1);
        check_frame("f4");
        handshake("f4");

        // rx_valid in the would-be timeout cycle wins
        send(8'hC1, 1'b0);
        for (int i = 0; i < TO - 1; i++) tick();
        send(8'hC2, 1'b0);
        chk("to_win_pulse", 32'(timeout_err), 32'd0);
        chk("to_win_count", 32'(byte_count), 32'd2);
        exp_q.push_back(32'hC4C3C2C1);
        send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        check_frame("f5");
        handshake("f5");

        // Reset mid-frame, rx_valid during reset ignored
        send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0);
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        tick();
        reset = 1'b0;
        chk("mrst_count", 32'(byte_count), 32'd0);
        chk("mrst_led", 32'(led), 32'd0);
        chk("mrst_data", frame_data, 32'd0);
        chk("mrst_overrun", 32'(overrun), 32'd0);
        send_frame(32'hE4E3E2E1);
        check_frame("f6");
        handshake("f6");

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
